// File: rtl/ipif_pkg.sv
// ipif_pkg: AXI4-Lite response codes shared by the IPIF slave files
package ipif_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/ipif_axil_wr_ctrl.sv
// ipif_axil_wr_ctrl: AW/W capture in any order, byte-strobe register merge, B response
module ipif_axil_wr_ctrl
  import ipif_pkg::*;
#(
  parameter int DW = 32,
  parameter int IW = 6,
  parameter int N_REG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     aw_idx,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [DW-1:0]     w_data,
  input  logic [DW/8-1:0]   w_strb,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [1:0]        b_resp,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [N_REG-1:0]  wr_ce,
  output logic [N_REG*DW-1:0] params
);
  logic en, aw_held, w_held, exec;
  logic [IW-1:0] idx;
  logic [DW-1:0] data;
  logic [DW/8-1:0] strb;
  logic [N_REG-1:0] hit;
  for (genvar i = 0; i < N_REG; i++) begin : g_hit
    assign hit[i] = 32'(idx) == i;
  end
  assign exec = aw_held && w_held && !b_valid;
  assign aw_ready = en && !aw_held && !b_valid;
  assign w_ready = en && !w_held && !b_valid;
  assign wr_ce = exec ? hit : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      idx <= '0;
      data <= '0;
      strb <= '0;
      b_valid <= 1'b0;
      b_resp <= RESP_OKAY;
      params <= '0;
    end else begin
      en <= 1'b1;
      if (aw_valid && aw_ready) begin
        aw_held <= 1'b1;
        idx <= aw_idx;
      end
      if (w_valid && w_ready) begin
        w_held <= 1'b1;
        data <= w_data;
        strb <= w_strb;
      end
      if (exec) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        b_valid <= 1'b1;
        b_resp <= |hit ? RESP_OKAY : RESP_SLVERR;
      end else if (b_ready)
        b_valid <= 1'b0;
      for (int i = 0; i < N_REG; i++)
        for (int b = 0; b < DW/8; b++)
          if (wr_ce[i] && strb[b]) params[DW*i+8*b +: 8] <= data[8*b +: 8];
    end
endmodule

// File: rtl/ipif_axil_slave.sv
// ipif_axil_slave: AXI4-Lite slave exposing N_REG 32-bit registers with one-hot
// read/write strobes toward a clock-domain converter
module ipif_axil_slave
  import ipif_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int N_REG = 2
) (
  input  logic                          bus_clk,
  input  logic                          bus_clk_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [N_REG-1:0]              RdCE,
  output logic [N_REG-1:0]              WrCE,
  output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_from_bus,
  input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_to_bus
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  logic en, unused_lsb;
  logic [IW-1:0] ar_idx;
  logic [N_REG-1:0] rd_hot;
  logic [DW-1:0] rd_word;
  assign unused_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign S_AXI_ARREADY = en && !S_AXI_RVALID;
  // out-of-range indices match no register, giving zero data and no strobe
  always_comb begin
    rd_word = '0;
    rd_hot = '0;
    for (int i = 0; i < N_REG; i++)
      if (32'(ar_idx) == i) begin
        rd_word = params_to_bus[DW*i +: DW];
        rd_hot[i] = 1'b1;
      end
  end
  always_ff @(posedge bus_clk or negedge bus_clk_aresetn)
    if (!bus_clk_aresetn) begin
      en <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
      RdCE <= '0;
    end else begin
      en <= 1'b1;
      RdCE <= '0;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA <= rd_word;
        S_AXI_RRESP <= |rd_hot ? RESP_OKAY : RESP_SLVERR;
        RdCE <= rd_hot;
      end else if (S_AXI_RREADY)
        S_AXI_RVALID <= 1'b0;
    end
  ipif_axil_wr_ctrl #(.DW(DW), .IW(IW), .N_REG(N_REG)) u_wr (
    .clk(bus_clk),
    .rst_n(bus_clk_aresetn),
    .aw_idx(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
    .aw_valid(S_AXI_AWVALID),
    .aw_ready(S_AXI_AWREADY),
    .w_data(S_AXI_WDATA),
    .w_strb(S_AXI_WSTRB),
    .w_valid(S_AXI_WVALID),
    .w_ready(S_AXI_WREADY),
    .b_resp(S_AXI_BRESP),
    .b_valid(S_AXI_BVALID),
    .b_ready(S_AXI_BREADY),
    .wr_ce(WrCE),
    .params(params_from_bus)
  );
endmodule

// File: tb/tb_ipif_axil_slave.sv
// tb_ipif_axil_slave: directed checks of the AXI4-Lite register slave
module tb_ipif_axil_slave;
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp, rdce, wrce;
  logic [31:0] rdata;
  logic [63:0] pfb, ptb = '0, ptb_mux;
  logic loop = 1'b0;
  int total = 0, bad = 0, wr_cnt = 0, rd_cnt = 0, multi = 0;
  logic [1:0] r;
  logic [31:0] d;
  logic [1:0] rr;

  assign ptb_mux = loop ? pfb : ptb;
  always #5 clk = ~clk;

  ipif_axil_slave dut (
    .bus_clk(clk), .bus_clk_aresetn(rstn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .RdCE(rdce), .WrCE(wrce), .params_from_bus(pfb), .params_to_bus(ptb_mux)
  );

  always @(negedge clk) begin
    if (wrce != 0) wr_cnt++;
    if (rdce != 0) rd_cnt++;
    if ($countones(wrce) > 1 || $countones(rdce) > 1) multi++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] dv, input logic [3:0] s, output logic [1:0] resp);
    int n;
    awaddr = a; awvalid = 1'b1; wdata = dv; wstrb = s; wvalid = 1'b1;
    cyc;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 10) begin cyc; n++; end
    if (!bvalid) chk("b_timeout", 0, 1);
    resp = bresp;
    cyc;
    bready = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] dv, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1;
    cyc;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 10) begin cyc; n++; end
    if (!rvalid) chk("r_timeout", 0, 1);
    dv = rdata; resp = rresp;
    cyc;
    rready = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) cyc;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_valids", {bvalid, rvalid}, 0);
    chk("rst_params", pfb, 0);
    rstn = 1'b1;
    cyc;
    chk("rel_readies", {awready, wready, arready}, 3'b111);

    // AW then W three cycles later
    wr_cnt = 0;
    awaddr = 8'h04; awvalid = 1'b1;
    cyc;
    awvalid = 1'b0;
    chk("aw_held_awready", awready, 0);
    cyc; cyc;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    cyc;
    wvalid = 1'b0;
    chk("aww_wrce", wrce, 2'b10);
    chk("aww_bvalid_early", bvalid, 0);
    cyc;
    chk("aww_wrce_off", wrce, 0);
    chk("aww_bvalid", bvalid, 1);
    chk("aww_bresp", bresp, 2'b00);
    chk("aww_reg1", pfb[63:32], 32'hDEADBEEF);
    chk("aww_block_aw", awready, 0);
    bready = 1'b1;
    cyc;
    bready = 1'b0;
    chk("aww_bclear", bvalid, 0);
    chk("aww_wrce_cnt", wr_cnt, 1);

    // W before AW with partial strobe
    wr(8'h00, 32'h11223344, 4'hF, r);
    wdata = 32'hAABBCCDD; wstrb = 4'h5; wvalid = 1'b1;
    cyc;
    wvalid = 1'b0;
    chk("waw_wready", wready, 0);
    cyc;
    awaddr = 8'h00; awvalid = 1'b1;
    cyc;
    awvalid = 1'b0;
    chk("waw_wrce", wrce, 2'b01);
    bready = 1'b1;
    cyc;
    chk("waw_bresp", {bvalid, bresp}, 3'b100);
    cyc;
    bready = 1'b0;
    chk("waw_reg0", pfb[31:0], 32'h11BB33DD);

    // read with backpressure
    ptb = {32'hCAFEF00D, 32'h12345678};
    rd_cnt = 0;
    araddr = 8'h00; arvalid = 1'b1;
    cyc;
    arvalid = 1'b0;
    ptb[31:0] = 32'h0;
    chk("rbp_rdce", rdce, 2'b01);
    for (int i = 0; i < 4; i++) begin
      chk("rbp_hold", {rvalid, rdata}, {1'b1, 32'h12345678});
      cyc;
    end
    rready = 1'b1;
    cyc;
    rready = 1'b0;
    chk("rbp_rclear", rvalid, 0);
    chk("rbp_rdce_cnt", rd_cnt, 1);
    rd(8'h04, d, rr);
    chk("rd_word1", {rr, d}, {2'b00, 32'hCAFEF00D});

    // out-of-range write and read
    wr_cnt = 0; rd_cnt = 0;
    wr(8'h08, 32'hFFFFFFFF, 4'hF, r);
    chk("oor_bresp", r, 2'b10);
    rd(8'h08, d, rr);
    chk("oor_read", {rr, d}, {2'b10, 32'h0});
    chk("oor_strobes", {wr_cnt[7:0], rd_cnt[7:0]}, 0);
    chk("oor_regs", pfb, {32'hDEADBEEF, 32'h11BB33DD});

    // zero strobe write
    wr_cnt = 0;
    wr(8'h04, 32'h0, 4'h0, r);
    chk("zs_bresp", r, 2'b00);
    chk("zs_wrce_cnt", wr_cnt, 1);
    chk("zs_reg1", pfb[63:32], 32'hDEADBEEF);

    // read coinciding with the write-execute edge, readback looped
    loop = 1'b1;
    wr(8'h04, 32'h0, 4'hF, r);
    wr_cnt = 0; rd_cnt = 0;
    awaddr = 8'h04; awvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
    cyc;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h04; arvalid = 1'b1;
    chk("cc_wrce", wrce, 2'b10);
    cyc;
    arvalid = 1'b0;
    chk("cc_rdata", {rvalid, rdata}, {1'b1, 32'h0});
    chk("cc_rdce", rdce, 2'b10);
    chk("cc_bvalid", bvalid, 1);
    bready = 1'b1; rready = 1'b1;
    cyc;
    bready = 1'b0; rready = 1'b0;
    chk("cc_counts", {wr_cnt[7:0], rd_cnt[7:0]}, 16'h0101);
    chk("cc_reg1", pfb[63:32], 32'h55AA55AA);
    rd(8'h04, d, rr);
    chk("cc_reread", d, 32'h55AA55AA);
    loop = 1'b0;

    // reset mid-transaction
    ptb = {32'h0, 32'h77777777};
    awaddr = 8'h00; awvalid = 1'b1; araddr = 8'h00; arvalid = 1'b1;
    cyc;
    awvalid = 1'b0; arvalid = 1'b0;
    wr_cnt = 0;
    #2 rstn = 1'b0;
    #1;
    chk("mid_outs", {rvalid, rdata, bvalid, rdce, wrce}, 0);
    chk("mid_readies", {awready, wready, arready}, 0);
    chk("mid_params", pfb, 0);
    repeat (2) cyc;
    rstn = 1'b1;
    cyc;
    chk("mid_after", {bvalid, awready}, 2'b01);
    chk("mid_no_strobe", wr_cnt, 0);
    wr(8'h04, 32'h0BADCAFE, 4'hF, r);
    chk("mid_next_wr", {r, pfb}, {2'b00, 32'h0BADCAFE, 32'h0});

    chk("onehot", multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ipif_axil_slave.md
IPIF_AXIL_SLAVE -- requirements
Module: ipif_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: register and AXI data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8: byte-address width; at least clog2(N_REG)+2.
REQ-003 SHALL have parameter N_REG, default 2: number of 32-bit registers.
REQ-004 SHALL have port bus_clk, input, 1 bit: sole clock.
REQ-005 SHALL have port bus_clk_aresetn, input, 1 bit: asynchronous reset, active low.
REQ-006 SHALL have ports S_AXI_AWADDR/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY, S_AXI_ARADDR/ARVALID/ARREADY and S_AXI_RDATA/RRESP/RVALID/RREADY: a standard AXI4-Lite slave, widths per the parameters.
REQ-007 SHALL have port RdCE, output, N_REG bits: one-hot read strobe, one bus_clk pulse.
REQ-008 SHALL have port WrCE, output, N_REG bits: one-hot write strobe, one bus_clk pulse.
REQ-009 SHALL have port params_from_bus, output, N_REG*C_S_AXI_DATA_WIDTH bits: register file contents, register i at bits [32i+31:32i].
REQ-010 SHALL have port params_to_bus, input, N_REG*C_S_AXI_DATA_WIDTH bits: readback values, same layout.

Function
REQ-011 SHALL give register i the word index ADDR[ADDR_WIDTH-1:2]; bits [1:0] are ignored.
REQ-012 SHALL capture AW and W independently and in either order.
- AWREADY is high while no address is held; WREADY is high while no data is held.
- Each is held until the write executes.
REQ-013 SHALL execute a write on the first edge where both address and data are held and BVALID is low:
- For each WSTRB bit set, the matching byte of register idx is updated.
- WrCE[idx] pulses for exactly that one cycle.
- BVALID rises on the next cycle.
REQ-014 SHALL hold BVALID and BRESP until BREADY; no new AW or W is accepted while BVALID is high.
REQ-015 SHALL treat idx >= N_REG on a write as a decode error:
- No register change and no WrCE.
- BRESP = SLVERR (2'b10); in-range writes give OKAY (2'b00).
REQ-016 SHALL drive ARREADY high when RVALID is low.
REQ-017 SHALL, on an AR handshake at edge N:
- Assert RVALID from N+1.
- Present RDATA = params_to_bus word idx as sampled at edge N.
- Pulse RdCE[idx] for the single cycle after N.
REQ-018 SHALL hold RVALID, RDATA and RRESP stable until RREADY.
REQ-019 SHALL answer an out-of-range read with RDATA = 0, RRESP = SLVERR and no RdCE.
REQ-020 SHALL run the read and write channels fully concurrently; a read and a write to the same register in the same cycle return the pre-write readback value.
REQ-021 SHALL never assert more than one bit of WrCE, or of RdCE, in any cycle.
REQ-022 SHALL hold the WSTRB = 0 case as an OKAY write with WrCE pulse and no data change.

Reset
REQ-023 SHALL, while bus_clk_aresetn is low, asynchronously force:
- params_from_bus = 0, RdCE = 0, WrCE = 0.
- BVALID = RVALID = 0, BRESP = RRESP = 0, RDATA = 0.
- Held address/data flags cleared.
REQ-024 SHALL drive AWREADY, WREADY and ARREADY low during reset and high from the first edge after release.
REQ-025 SHALL abandon any transaction in flight when reset asserts mid-operation: no strobe, no response, no partial register update.

Structure
REQ-026 SHALL take the AXI response constants OKAY and SLVERR from the shared package ipif_pkg.
REQ-027 SHALL keep the write path (AW/W capture, strobe merge, B response) in one sub-module, ipif_axil_wr_ctrl; the read path stays in the top module.
REQ-028 SHALL connect RdCE, WrCE, params_from_bus and params_to_bus directly to the bus side of the clock-domain converter, with no extra registering.

Verification
REQ-029 SHALL cover the AW-then-W ordering:
- Stimulus: AW 0x04, then W 0xDEADBEEF with WSTRB 0xF three cycles later.
- Required response: register 1 = 0xDEADBEEF; WrCE = 2'b10 for one cycle; BRESP = OKAY.
REQ-030 SHALL cover W-before-AW with a partial strobe:
- Stimulus: register 0 = 0x11223344; then W 0xAABBCCDD with WSTRB 0x5, and AW 0x00 two cycles later.
- Required response: register 0 = 0x11BB33DD.
REQ-031 SHALL cover a read with backpressure:
- Stimulus: params_to_bus word 0 = 0x12345678; AR 0x00; RREADY held low for 4 cycles.
- Required response: RDATA = 0x12345678 stable throughout; RdCE = 2'b01 pulses exactly once.
REQ-032 SHALL cover out-of-range accesses:
- Stimulus: write and read at 0x08 with N_REG = 2.
- Required response: SLVERR on both; RDATA = 0; no strobes; registers unchanged.
REQ-033 SHALL cover concurrent access:
- Stimulus: simultaneous write 0x04 and read 0x04, with params_to_bus looped from params_from_bus; prior value 0.
- Required response: read returns 0; WrCE and RdCE both pulse.
REQ-034 SHALL cover reset mid-transaction:
- Stimulus: assert reset with AW held and BREADY low.
- Required response: all outputs are 0 immediately; after release, BVALID stays 0 and the next write completes normally.
